// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for mem_port_arbiter        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_GFX = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int WE_W_DEF   = DATA_W_DEF / 8;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// +----------------------------------------------------------------------+
// | mem_arb_pick : combinational grant between CPU and GFX requesters    |
// | MEM_ARB_RR_EN selects round-robin ties, otherwise CPU wins ties.     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_valid,
  input  logic gfx_valid,
  input  logic last_grant,
  output logic grant_cpu,
  output logic grant_gfx
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_cpu = 1'b0;
    grant_gfx = 1'b0;
    if (cpu_valid && gfx_valid) begin
      // Tie goes to whoever did not win last time.
      grant_cpu = (last_grant == OWN_GFX);
      grant_gfx = (last_grant == OWN_CPU);
    end else begin
      grant_cpu = cpu_valid;
      grant_gfx = gfx_valid;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_cpu = cpu_valid;
    grant_gfx = gfx_valid && !cpu_valid;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between CPU and GFX        |
// | Build option MEM_ARB_RR_EN enables round-robin tie-break.            |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WE_W   = WE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic [WE_W-1:0]   cpu_we,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              gfx_req_valid,
  output logic              gfx_req_ready,
  input  logic [ADDR_W-1:0] gfx_addr,
  input  logic [DATA_W-1:0] gfx_din,
  input  logic [WE_W-1:0]   gfx_we,
  output logic              gfx_rvalid,
  output logic [DATA_W-1:0] gfx_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [WE_W-1:0]   mem_we,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   last_grant;
  logic   grant_cpu;
  logic   grant_gfx;
  logic   cpu_hs;
  logic   gfx_hs;
  logic   cpu_pending;

  mem_arb_pick u_pick (
    .cpu_valid  (cpu_req_valid),
    .gfx_valid  (gfx_req_valid),
    .last_grant (last_grant),
    .grant_cpu  (grant_cpu),
    .grant_gfx  (grant_gfx)
  );

  assign cpu_req_ready = (state == ST_IDLE) && grant_cpu;
  assign gfx_req_ready = (state == ST_IDLE) && grant_gfx;
  assign cpu_hs        = cpu_req_valid && cpu_req_ready;
  assign gfx_hs        = gfx_req_valid && gfx_req_ready;

  // Pending covers the accept cycle through the completion cycle inclusive.
  assign cpu_pending = cpu_hs || ((state != ST_IDLE) && (owner == OWN_CPU));
  assign cpu_stall   = (cpu_req_valid && !cpu_req_ready) || cpu_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_CPU;
      last_grant <= OWN_GFX;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= '0;
    end else begin
      state <= state_nxt;
      if (cpu_hs) begin
        owner      <= OWN_CPU;
        last_grant <= OWN_CPU;
        mem_addr   <= cpu_addr;
        mem_din    <= cpu_din;
        mem_we     <= cpu_we;
      end else if (gfx_hs) begin
        owner      <= OWN_GFX;
        last_grant <= OWN_GFX;
        mem_addr   <= gfx_addr;
        mem_din    <= gfx_din;
        mem_we     <= gfx_we;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    cpu_rvalid    = 1'b0;
    gfx_rvalid    = 1'b0;
    cpu_rdata     = '0;
    gfx_rdata     = '0;
    case (state)
      ST_IDLE: begin
        if (cpu_hs || gfx_hs) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = (mem_we == '0) ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        // Responses are only routed here, so stray ones elsewhere vanish.
        if (owner == OWN_CPU) begin
          cpu_rvalid = mem_rvalid;
          cpu_rdata  = mem_rdata;
        end else begin
          gfx_rvalid = mem_rvalid;
          gfx_rdata  = mem_rdata;
        end
        if (mem_rvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
